// File: rtl/pulse_train_gen_if.sv
// Trigger/pulse bus for pulse_train_gen: master drives trig, slave returns the pulse and status.
interface pulse_train_gen_if #(
    parameter int unsigned PEND_W = 2
);
    logic              trig;
    logic              dout;
    logic              busy;
    logic              drop;
    logic [PEND_W-1:0] pend_cnt;

    modport master (
        output trig,
        input  dout,
        input  busy,
        input  drop,
        input  pend_cnt
    );

    modport slave (
        input  trig,
        output dout,
        output busy,
        output drop,
        output pend_cnt
    );
endinterface

// File: rtl/pulse_train_gen.sv
// Turns trigger strobes into registered pulses of HIGH_W cycles followed by a LOW_W-cycle gap.
// Define PULSE_TRAIN_PEND_EN to queue triggers that arrive while a pulse is in progress.
module pulse_train_gen #(
    parameter int unsigned HIGH_W     = 4,
    parameter int unsigned LOW_W      = 2,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned PEND_DEPTH = 3,
    parameter int unsigned PEND_W     = 2
) (
    input  logic             clock,
    input  logic             rst_n,
    pulse_train_gen_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StHigh, StGap} state_e;

    localparam logic [CNT_W-1:0]  HighLast = CNT_W'(HIGH_W - 1);
    localparam logic [CNT_W-1:0]  LowLast  = CNT_W'(LOW_W - 1);
    localparam logic [PEND_W-1:0] PendMax  = PEND_W'(PEND_DEPTH);

    if (HIGH_W < 1 || HIGH_W > (1 << CNT_W) - 1 || LOW_W < 1 || LOW_W > (1 << CNT_W) - 1 ||
        PEND_DEPTH < 1 || PEND_DEPTH > (1 << PEND_W) - 1) begin : g_bad_params
        $error("pulse_train_gen: parameter out of range");
    end

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              dout_q, dout_d;
    logic              busy_q, busy_d;
    logic              drop_q, drop_d;
    logic              gap_last;
    logic              mid_pulse;

    assign gap_last  = (state_q == StGap) && (cnt_q == LowLast);
    assign mid_pulse = (state_q == StHigh) || ((state_q == StGap) && !gap_last);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        drop_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.trig) begin
                    state_d = StHigh;
                    cnt_d   = '0;
                end
            end
            StHigh: begin
                if (cnt_q == HighLast) begin
                    state_d = StGap;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StGap: begin
                if (gap_last) begin
                    cnt_d = '0;
                    // A queued request wins; a fresh trig then simply replaces it in the queue.
                    if (pend_q != '0) begin
                        state_d = StHigh;
                        if (!bus.trig) begin
                            pend_d = pend_q - PEND_W'(1);
                        end
                    end else if (bus.trig) begin
                        state_d = StHigh;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        if (mid_pulse && bus.trig) begin
`ifdef PULSE_TRAIN_PEND_EN
            if (pend_q != PendMax) begin
                pend_d = pend_q + PEND_W'(1);
            end else begin
                drop_d = 1'b1;
            end
`else
            drop_d = (PendMax == PendMax);
`endif
        end

        dout_d = (state_d == StHigh);
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pend_q  <= '0;
            dout_q  <= 1'b0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.dout     = dout_q;
    assign bus.busy     = busy_q;
    assign bus.drop     = drop_q;
    assign bus.pend_cnt = pend_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench for pulse_train_gen: directed scenarios plus random triggers against a
// timeline model that tracks each pulse by its start cycle.
module tb_pulse_train_gen;

    localparam int H = 4;
    localparam int L = 2;
    localparam int P = H + L;
    localparam int D = 3;
`ifdef PULSE_TRAIN_PEND_EN
    localparam bit QueueEn = 1'b1;
`else
    localparam bit QueueEn = 1'b0;
`endif

    logic clock = 1'b0;
    logic rst_n;
    always #5 clock = ~clock;

    pulse_train_gen_if #(.PEND_W(2)) bus ();

    pulse_train_gen #(
        .HIGH_W    (H),
        .LOW_W     (L),
        .CNT_W     (8),
        .PEND_DEPTH(D),
        .PEND_W    (2)
    ) dut (
        .clock(clock),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: current pulse occupies cycles m_s .. m_s+P-1, high for the first H of them.
    bit m_act  = 1'b0;
    int m_s    = 0;
    int m_q    = 0;
    bit m_drop = 1'b0;
    int edge_k = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_act  = 1'b0;
        m_q    = 0;
        m_drop = 1'b0;
    endtask

    task automatic model_edge(input bit t);
        int  k;
        bit  in_pulse;
        bit  last;
        k        = edge_k;
        edge_k   = edge_k + 1;
        in_pulse = m_act && (k <= m_s + P - 1);
        last     = in_pulse && (k == m_s + P - 1);
        m_drop   = 1'b0;
        if (!in_pulse) begin
            m_act = t;
            if (t) m_s = k + 1;
        end else if (last) begin
            if (m_q > 0) begin
                m_q = m_q - 1 + (t ? 1 : 0);
                m_s = k + 1;
            end else if (t) begin
                m_s = k + 1;
            end else begin
                m_act = 1'b0;
            end
        end else if (t) begin
            if (QueueEn && m_q < D) m_q = m_q + 1;
            else m_drop = 1'b1;
        end
    endtask

    task automatic compare(input string tag);
        int c;
        c = edge_k;
        check({tag, ".dout"}, bus.dout, m_act && c >= m_s && c <= m_s + H - 1);
        check({tag, ".busy"}, bus.busy, m_act && c <= m_s + P - 1);
        check({tag, ".drop"}, bus.drop, m_drop);
        check({tag, ".pend"}, bus.pend_cnt, m_q);
    endtask

    // Called at a falling edge: drive trig, let one rising edge pass, check at the next fall.
    task automatic step(input bit t, input string tag);
        bus.trig = t;
        @(posedge clock);
        model_edge(t);
        @(negedge clock);
        compare(tag);
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, tag);
    endtask

    initial begin
        rst_n    = 1'b0;
        bus.trig = 1'b0;
        repeat (3) @(negedge clock);
        check("rst.dout", bus.dout, 1'b0);
        check("rst.busy", bus.busy, 1'b0);
        check("rst.drop", bus.drop, 1'b0);
        check("rst.pend", bus.pend_cnt, 2'd0);
        rst_n = 1'b1;
        model_reset();

        idle_cycles(2, "pre");

        step(1'b1, "single");
        idle_cycles(10, "single");

        for (int i = 0; i < 5; i++) step(1'b1, "burst");
        idle_cycles(30, "burst");

        step(1'b1, "lastgap");
        idle_cycles(5, "lastgap");
        step(1'b1, "lastgap");
        idle_cycles(15, "lastgap");

        for (int i = 0; i < 4; i++) step(1'b1, "fullq");
        idle_cycles(2, "fullq");
        step(1'b1, "fullq");
        idle_cycles(30, "fullq");

        for (int i = 0; i < 3; i++) step(1'b1, "midrst");
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.dout", bus.dout, 1'b0);
        check("midrst.busy", bus.busy, 1'b0);
        check("midrst.pend", bus.pend_cnt, 2'd0);
        model_reset();
        @(negedge clock);
        rst_n = 1'b1;
        idle_cycles(12, "postrst");

        for (int d = 0; d < 4; d++) begin
            int pct;
            pct = 10 + d * 27;
            for (int i = 0; i < 120; i++) begin
                step($urandom_range(99, 0) < pct, "rand");
            end
        end
        idle_cycles(40, "drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
